stream_bitpack: RTL and testbench
=================================

// Module: stream_bitpack
// PURPOSE
//  Streaming, parametrised successor to the combinational polynomial packer.
//  Accepts one coefficient per handshake and packs the low bitlen bits of each into OUT_W-bit words.
//  bitlen is chosen at run time, per polynomial. Word order is little-endian: coeff 0 lands in bit 0 of word 0.
//  Sits between the NTT/decompose datapath and the signature/key byte-stream serializer.
// PARAMETERS
//  COEFF_W   23    max coefficient width on in_coeff
//  OUT_W     64    output word width (COEFF_W <= OUT_W required; elaboration $error otherwise)
//  N_COEFF   256   coefficients per polynomial
//  BLEN_W    5     width of bitlen port (2**BLEN_W > COEFF_W)
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         async active-low reset
//  start        in   1         begin one polynomial; sampled only in IDLE
//  bitlen       in   BLEN_W    bits per coefficient, latched on accepted start; legal 1..COEFF_W
//  bound        in   COEFF_W   offset b, latched on start (used only with STREAM_BITPACK_OFFSET_EN)
//  in_valid     in   1         coefficient valid
//  in_ready     out  1         coefficient accepted when in_valid&&in_ready
//  in_coeff     in   COEFF_W   coefficient value
//  out_valid    out  1         packed word valid
//  out_ready    in   1         downstream accepts word
//  out_data     out  OUT_W     packed word
//  out_last     out  1         final word of polynomial, qualified by out_valid
//  busy         out  1         high from accepted start until last word accepted
//  done         out  1         one-cycle pulse the cycle after last word accepted
//  err          out  1         sticky: start seen with bitlen==0 or >COEFF_W; cleared by next legal start
// BEHAVIOUR
//  Reset: state=IDLE; acc, fill, count, all outputs 0; in_ready=0.
//  FSM: IDLE -start&&legal-> RUN -N_COEFF coeffs accepted-> FLUSH -last word accepted-> IDLE (done=1).
//   Illegal start: stay IDLE, set err. Start while busy: ignored.
//  Accumulator acc is OUT_W+COEFF_W bits; fill is 0..OUT_W+COEFF_W-1.
//   Value packed = in_coeff masked to bitlen bits; higher bits are discarded silently.
//   Packed value is placed at bit position fill (after any same-cycle output shift).
//  out_valid = (fill>=OUT_W) || (state==FLUSH && fill>0).
//   out_data = acc[OUT_W-1:0]; in FLUSH, bits >= fill read 0 (zero padding).
//  Output fire shifts acc right by OUT_W and sets fill=max(fill-OUT_W,0).
//  in_ready = (state==RUN) && (fill<OUT_W || (out_valid && out_ready)). Comb path out_ready->in_ready is allowed.
//  Simultaneous in/out fire: shift first, then insert at fill-OUT_W. No bubble; 1 coeff/cycle sustained with out_ready=1.
//  out_last = out_valid && remaining bits <= OUT_W after the final coeff accepted.
//   Cover the case where the final coeff completes an exact word: that word is last and FLUSH then has fill==0.
//  Exact fit (N_COEFF*bitlen % OUT_W == 0): no padding word is emitted.
//  Word count = ceil(N_COEFF*bitlen/OUT_W). Latency: first word valid 1 cycle after the fire that fills it.
//  out_valid/out_data hold stable while out_valid && !out_ready.
//  Async reset mid-polynomial: everything is discarded, partial words are never emitted, and no done pulse occurs.
// CONFIGURATION
//  `STREAM_BITPACK_OFFSET_EN defined: the packed value is (bound - in_coeff) mod 2^bitlen.
//   The subtract is registered in one extra input pipeline stage, so in_ready also depends on that stage being free.
//  Undefined: the packed value is in_coeff directly; the bound port is unused, and there is no pipeline stage.
// STRUCTURE
//  Package bitpack_pkg: state_e {IDLE,RUN,FLUSH}, N_COEFF_DEF=256, function words_for(bitlen, out_w).
//  Sub-module bitpack_shift_acc: acc/fill register plus insert/shift datapath.
//   The top-level module keeps the FSM, the coefficient counter ($clog2(N_COEFF+1) bits) and the handshakes.
// TESTING
//  bitlen=4, OUT_W=64, coeff i = i&15, out_ready=1 -> 16 words.
//   Word 0 = 64'hFEDCBA9876543210; last asserted on word 15; done 1 cycle later.
//  bitlen=13, coeffs all 13'h1FFF -> 52 words of all ones.
//   Word 51 low 64 bits all ones; no padding; out_last on word 51.
//  bitlen=10, coeffs=0x3FF, out_ready toggled 1/0 randomly -> 40 words of ones; data stable while stalled.
//  bitlen=3 with in_coeff=23'h7FFFF8 -> all packed bits 0 (masking). bitlen=0 start -> err=1, busy stays 0.
//  rst_n low after 100 coeffs, then a new start with bitlen=6 -> first word reflects only new coeffs; no stale bits.
//  OFFSET_EN, bitlen=4, bound=4, coeffs cycling -4..4 -> packed values 8..0.
//   Word 0 matches the reference model; compare every run against the golden SimpleBitPack-style model.

Source files
------------

// File: rtl/stream_bitpack_pkg.sv
// Shared types and helpers for the streaming coefficient bit-packer.
// Holds the FSM state encoding, the default polynomial size and a word-count helper.
package bitpack_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_e;

    localparam int N_COEFF_DEF = 256;

    // Packed words needed for one polynomial of N_COEFF_DEF coefficients.
    function automatic int words_for(input int bitlen, input int out_w);
        return (N_COEFF_DEF * bitlen + out_w - 1) / out_w;
    endfunction

endpackage

// File: rtl/stream_bitpack_shift_acc.sv
// Bit accumulator for stream_bitpack: holds acc/fill and performs the
// output shift and the coefficient insert (shift first, then insert) each cycle.
module bitpack_shift_acc
    import bitpack_pkg::*;
#(
    parameter int COEFF_W = 23,
    parameter int OUT_W   = 64,
    parameter int BLEN_W  = 5,
    parameter int FILL_W  = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic               i_shift,
    input  logic               i_ins,
    input  logic [COEFF_W-1:0] i_val,
    input  logic [BLEN_W-1:0]  i_len,
    output logic [OUT_W-1:0]   o_word,
    output logic [FILL_W-1:0]  o_fill
);

    localparam int ACC_W = OUT_W + COEFF_W;
    localparam logic [FILL_W-1:0] OW_F = FILL_W'(OUT_W);

    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_acc_s;
    logic [ACC_W-1:0]  w_acc_n;
    logic [FILL_W-1:0] r_fill;
    logic [FILL_W-1:0] w_fill_s;
    logic [FILL_W-1:0] w_fill_n;

    // Drop the emitted word, then append the new value just above the remaining bits.
    always_comb begin
        w_acc_s  = r_acc;
        w_fill_s = r_fill;
        if (i_shift) begin
            w_acc_s  = r_acc >> OUT_W;
            w_fill_s = (r_fill >= OW_F) ? (r_fill - OW_F) : '0;
        end
        w_acc_n  = w_acc_s;
        w_fill_n = w_fill_s;
        if (i_ins) begin
            w_acc_n  = w_acc_s | (ACC_W'(i_val) << w_fill_s);
            w_fill_n = w_fill_s + FILL_W'(i_len);
        end
    end

    // Accumulator state; bits above fill are always zero, which gives the flush padding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (i_clr) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else begin
            r_acc  <= w_acc_n;
            r_fill <= w_fill_n;
        end
    end

    assign o_word = r_acc[OUT_W-1:0];
    assign o_fill = r_fill;

endmodule

// File: rtl/stream_bitpack.sv
// Streaming polynomial packer: low bitlen bits of each coefficient, little-endian, into OUT_W words.
// Optional STREAM_BITPACK_OFFSET_EN packs (bound - coeff) through one registered input stage.
module stream_bitpack
    import bitpack_pkg::*;
#(
    parameter int COEFF_W = 23,
    parameter int OUT_W   = 64,
    parameter int N_COEFF = N_COEFF_DEF,
    parameter int BLEN_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BLEN_W-1:0]  bitlen,
    input  logic [COEFF_W-1:0] bound,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEFF_W-1:0] in_coeff,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int ACC_W  = OUT_W + COEFF_W;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int CNT_W  = $clog2(N_COEFF + 1);
    localparam logic [FILL_W-1:0] OW_F   = FILL_W'(OUT_W);
    localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(N_COEFF - 1);

    if (COEFF_W > OUT_W) begin : g_bad_width
        $error("stream_bitpack: COEFF_W must not exceed OUT_W");
    end

    state_e             r_state;
    state_e             w_next;
    logic [BLEN_W-1:0]  r_bitlen;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;
    logic               r_done;
    logic [FILL_W-1:0]  w_fill;
    logic [COEFF_W-1:0] w_mask;
    logic [COEFF_W-1:0] w_ins_val;
    logic               w_legal;
    logic               w_start_ok;
    logic               w_ins_ok;
    logic               w_ins;
    logic               w_last_ins;
    logic               w_in_fire;
    logic               w_out_fire;

    assign w_legal    = (bitlen != '0) && (bitlen <= BLEN_W'(COEFF_W));
    assign w_start_ok = start && w_legal && (r_state == IDLE);
    assign w_mask     = (COEFF_W'(1) << r_bitlen) - COEFF_W'(1);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_last_ins = w_ins && (r_count == LAST_C);

`ifdef STREAM_BITPACK_OFFSET_EN
    logic               r_pv;
    logic [COEFF_W-1:0] r_pval;
    logic [COEFF_W-1:0] r_bound;
    logic [CNT_W-1:0]   r_in_cnt;

    assign w_ins     = r_pv && w_ins_ok;
    assign w_ins_val = r_pval;

    // Offset subtract stage; holds one coefficient until the accumulator takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv     <= 1'b0;
            r_pval   <= '0;
            r_bound  <= '0;
            r_in_cnt <= '0;
        end else if (w_start_ok) begin
            r_pv     <= 1'b0;
            r_bound  <= bound;
            r_in_cnt <= '0;
        end else begin
            if (w_in_fire) begin
                r_pv     <= 1'b1;
                r_pval   <= (r_bound - in_coeff) & w_mask;
                r_in_cnt <= r_in_cnt + 1'b1;
            end else if (w_ins) begin
                r_pv <= 1'b0;
            end
        end
    end
`else
    logic w_unused_bound;

    assign w_unused_bound = ^bound;
    assign w_ins          = w_in_fire;
    assign w_ins_val      = in_coeff & w_mask;
`endif

    bitpack_shift_acc #(
        .COEFF_W (COEFF_W),
        .OUT_W   (OUT_W),
        .BLEN_W  (BLEN_W),
        .FILL_W  (FILL_W)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_start_ok),
        .i_shift (w_out_fire),
        .i_ins   (w_ins),
        .i_val   (w_ins_val),
        .i_len   (r_bitlen),
        .o_word  (out_data),
        .o_fill  (w_fill)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // FSM next state: run until all coefficients are in, flush until last word leaves.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start_ok) w_next = RUN;
            RUN:     if (w_last_ins) w_next = FLUSH;
            FLUSH:   if ((w_out_fire && out_last) || (w_fill == '0)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs and handshakes; in_ready sees out_ready combinationally.
    always_comb begin
        out_valid = (w_fill >= OW_F) || ((r_state == FLUSH) && (w_fill != '0));
        out_last  = out_valid && (r_state == FLUSH) && (w_fill <= OW_F);
        busy      = (r_state != IDLE);
        w_ins_ok  = (w_fill < OW_F) || (out_valid && out_ready);
`ifdef STREAM_BITPACK_OFFSET_EN
        in_ready  = (r_state == RUN) && (r_in_cnt != CNT_W'(N_COEFF)) &&
                    (!r_pv || w_ins_ok);
`else
        in_ready  = (r_state == RUN) && w_ins_ok;
`endif
    end

    // Per-polynomial settings, coefficient counter, sticky error and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitlen <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == FLUSH) && w_out_fire && out_last;
            if (start && (r_state == IDLE)) r_err <= !w_legal;
            if (w_start_ok) begin
                r_bitlen <= bitlen;
                r_count  <= '0;
            end else if (w_ins) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_stream_bitpack.sv
// Directed bench for stream_bitpack with a bit-serial packing model feeding a scoreboard.
// Optional STREAM_BITPACK_OFFSET_EN adds an offset-packing run.
module tb_stream_bitpack;

    localparam int CW = 23;
    localparam int OW = 64;
    localparam int N  = 256;
    localparam int BW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [BW-1:0] bitlen = '0;
    logic [CW-1:0] bnd = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_coeff = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    stream_bitpack #(
        .COEFF_W (CW),
        .OUT_W   (OW),
        .N_COEFF (N),
        .BLEN_W  (BW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bitlen    (bitlen),
        .bound     (bnd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coeff  (in_coeff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct packed {
        logic [OW-1:0] d;
        logic          l;
    } exp_t;

    exp_t          q[$];
    logic [CW-1:0] c[N];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [OW-1:0] obs,
                       input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] pk(input logic [CW-1:0] v, input int bl);
        logic [CW-1:0] m = '0;
        for (int k = 0; k < bl; k++) m[k] = 1'b1;
`ifdef STREAM_BITPACK_OFFSET_EN
        return (bnd - v) & m;
`else
        return v & m;
`endif
    endfunction

    // Bit-serial reference: lay each coefficient's bits down one at a time.
    task automatic model_push(input int bl);
        logic [OW-1:0] w = '0;
        logic [CW-1:0] v;
        int            pos = 0;
        for (int i = 0; i < N; i++) begin
            v = pk(c[i], bl);
            for (int b = 0; b < bl; b++) begin
                w[pos] = v[b];
                pos++;
                if (pos == OW) begin
                    q.push_back('{d: w, l: (i == N - 1) && (b == bl - 1)});
                    w   = '0;
                    pos = 0;
                end
            end
        end
        if (pos > 0) q.push_back('{d: w, l: 1'b1});
    endtask

    task automatic run_poly(input string tag, input int bl, input int kind,
                            input int stall, input logic [CW-1:0] b);
        int            idx = 0;
        int            nw = 0;
        int            cyc = 0;
        int            exp_w;
        exp_t          e;
        logic          stalled = 1'b0;
        logic [OW-1:0] held = '0;
        logic [OW-1:0] first = '0;
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       c[i] = CW'(i & 15);
                1:       c[i] = CW'(13'h1FFF);
                2:       c[i] = CW'(10'h3FF);
                3:       c[i] = 23'h7FFFF8;
                5:       c[i] = CW'((i % 9) - 4);
                default: c[i] = CW'($urandom);
            endcase
        end
        bnd = b;
        model_push(bl);
        exp_w = (N * bl + OW - 1) / OW;
        @(negedge clk);
        start  = 1'b1;
        bitlen = BW'(bl);
        @(negedge clk);
        start  = (stall != 0);
        bitlen = '0;
        #1;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_err_clr"}, 64'(err), 64'd0);
        while (nw < exp_w && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (idx < N);
            in_coeff  = (idx < N) ? c[idx] : '0;
            out_ready = (stall != 0) ? 1'($urandom % 2) : 1'b1;
            #1;
            if (stalled) begin
                chk({tag, "_hold_v"}, 64'(out_valid), 64'd1);
                chk({tag, "_hold_d"}, out_data, held);
            end
            if (out_valid && out_ready) begin
                chk({tag, "_extra"}, 64'(q.size() == 0), 64'd0);
                e = (q.size() != 0) ? q.pop_front() : '0;
                chk($sformatf("%s_w%0d", tag, nw), out_data, e.d);
                chk($sformatf("%s_l%0d", tag, nw), 64'(out_last), 64'(e.l));
                if (nw == 0) first = out_data;
                nw++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (in_valid && in_ready) idx++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_nwords"}, 64'(nw), 64'(exp_w));
        chk({tag, "_ncoeff"}, 64'(idx), 64'(N));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        @(negedge clk);
        #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
`ifndef STREAM_BITPACK_OFFSET_EN
        if (kind == 0) chk({tag, "_word0"}, first, 64'hFEDCBA9876543210);
`endif
        q.delete();
    endtask

    task automatic bad_start(input string tag, input int bl);
        @(negedge clk);
        start  = 1'b1;
        bitlen = BW'(bl);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({tag, "_err"}, 64'(err), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        int idx;
        int cyc;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_poly("bl4", 4, 0, 0, '0);
        run_poly("bl13", 13, 1, 0, '0);
        run_poly("bl10", 10, 2, 1, '0);
        run_poly("bl3", 3, 3, 0, '0);
        bad_start("bl0", 0);
        bad_start("bl24", 24);
        run_poly("bl23", 23, 4, 1, '0);
        run_poly("bl1", 1, 4, 0, '0);

        @(negedge clk);
        start  = 1'b1;
        bitlen = BW'(6);
        @(negedge clk);
        start = 1'b0;
        idx   = 0;
        cyc   = 0;
        while (idx < 100 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b1;
            in_coeff = CW'($urandom);
            #1;
            if (in_valid && in_ready) idx++;
        end
        chk("mid_fed", 64'(idx), 64'd100);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_ready", 64'(in_ready), 64'd0);
        chk("mid_data", out_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_nodone", 64'(done), 64'd0);
        run_poly("bl6", 6, 4, 0, '0);

`ifdef STREAM_BITPACK_OFFSET_EN
        run_poly("off4", 4, 5, 1, 23'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
